// File: rtl/signed_add_rr_arbiter.sv
// Round-robin arbitrated, shared W-bit signed adder with overflow detection,
// a single registered result stage and a saturating overflow counter.
module signed_add_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_rdy,
  output logic               res_vld,
  input  logic               res_rdy,
  output logic [W-1:0]       res_sum,
  output logic               res_ovf,
  output logic [ID_W-1:0]    res_id,
  output logic [CNT_W-1:0]   ovf_cnt
);

  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] grant_id;
  logic            found;
  logic            can_accept;
  logic            accept;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W-1:0]    sum;
  logic            ovf;

  // Scan from the pointer upward, wrapping; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_vld[(int'(rr_ptr_reg) + k) % N_REQ]) begin
        found    = 1'b1;
        grant_id = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
      end
    end
  end

  // The result slot frees in the same cycle the old result drains.
  assign can_accept = !res_vld || res_rdy;
  assign accept     = found && can_accept && !rst;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rdy
      assign req_rdy[gi] = accept && (grant_id == ID_W'(gi));
    end
  endgenerate

  assign a_sel = req_a[int'(grant_id)*W +: W];
  assign b_sel = req_b[int'(grant_id)*W +: W];
  assign sum   = a_sel + b_sel;
  assign ovf   = (a_sel[W-1] == b_sel[W-1]) && (sum[W-1] != a_sel[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld    <= 1'b0;
      res_sum    <= '0;
      res_ovf    <= 1'b0;
      res_id     <= '0;
      ovf_cnt    <= '0;
      rr_ptr_reg <= '0;
    end else if (accept) begin
      res_vld    <= 1'b1;
      res_sum    <= sum;
      res_ovf    <= ovf;
      res_id     <= grant_id;
      rr_ptr_reg <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
      if (ovf && (ovf_cnt != {CNT_W{1'b1}}))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end else if (res_vld && res_rdy) begin
      res_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signed_add_rr_arbiter.sv
// Directed bench for signed_add_rr_arbiter: a default instance plus a
// CNT_W=2 instance used to exercise counter saturation.
module tb_signed_add_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_rdy;
  logic        res_vld;
  logic        res_rdy;
  logic [3:0]  res_sum;
  logic        res_ovf;
  logic [1:0]  res_id;
  logic [7:0]  ovf_cnt;

  logic [3:0]  s_req_vld;
  logic [15:0] s_req_a;
  logic [15:0] s_req_b;
  logic [3:0]  s_req_rdy;
  logic        s_res_vld;
  logic        s_res_rdy;
  logic [3:0]  s_res_sum;
  logic        s_res_ovf;
  logic [1:0]  s_res_id;
  logic [1:0]  s_ovf_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signed_add_rr_arbiter #(.N_REQ(4), .W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_sum(res_sum), .res_ovf(res_ovf), .res_id(res_id), .ovf_cnt(ovf_cnt)
  );

  signed_add_rr_arbiter #(.N_REQ(4), .W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_vld(s_req_vld), .req_a(s_req_a), .req_b(s_req_b),
    .req_rdy(s_req_rdy), .res_vld(s_res_vld), .res_rdy(s_res_rdy),
    .res_sum(s_res_sum), .res_ovf(s_res_ovf), .res_id(s_res_id), .ovf_cnt(s_ovf_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  initial begin
    rst = 1'b1;
    req_vld = '0; req_a = '0; req_b = '0; res_rdy = 1'b1;
    s_req_vld = '0; s_req_a = '0; s_req_b = '0; s_res_rdy = 1'b1;

    // Reset / idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("reset res_vld", res_vld, 0);
    check_eq("reset req_rdy", req_rdy, 4'b0000);
    check_eq("reset ovf_cnt", ovf_cnt, 0);
    check_eq("reset res_sum", res_sum, 0);
    check_eq("reset res_ovf", res_ovf, 0);
    check_eq("reset res_id", res_id, 0);

    // Single requester 2
    set_ops(2, 4'b0111, 4'b0001);
    req_vld = 4'b0100;
    #1;
    check_eq("single req_rdy", req_rdy, 4'b0100);
    tick();
    check_eq("7+1 sum", res_sum, 4'b1000);
    check_eq("7+1 ovf", res_ovf, 1);
    check_eq("7+1 id", res_id, 2);
    check_eq("7+1 vld", res_vld, 1);
    check_eq("7+1 cnt", ovf_cnt, 1);
    set_ops(2, 4'b1000, 4'b1111);
    tick();
    check_eq("-8-1 sum", res_sum, 4'b0111);
    check_eq("-8-1 ovf", res_ovf, 1);
    check_eq("-8-1 cnt", ovf_cnt, 2);
    set_ops(2, 4'b0101, 4'b1101);
    tick();
    check_eq("5-3 sum", res_sum, 4'b0010);
    check_eq("5-3 ovf", res_ovf, 0);
    check_eq("5-3 cnt", ovf_cnt, 2);
    req_vld = '0;
    tick();
    check_eq("drain vld", res_vld, 0);
    check_eq("drain sum held", res_sum, 4'b0010);
    check_eq("drain id held", res_id, 2);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'd1);
    req_vld = 4'b1111;
    #1;
    check_eq("rr rdy pre", req_rdy, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("rr id %0d", k), res_id, k % 4);
      check_eq($sformatf("rr sum %0d", k), res_sum, (k % 4) + 1);
      check_eq($sformatf("rr rdy %0d", k), req_rdy, 4'b0001 << ((k + 1) % 4));
    end

    // Backpressure with requester 1 waiting
    res_rdy = 1'b0;
    req_vld = 4'b0010;
    set_ops(1, 4'd3, 4'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("bp rdy %0d", k), req_rdy, 4'b0000);
      tick();
      check_eq($sformatf("bp vld %0d", k), res_vld, 1);
      check_eq($sformatf("bp sum %0d", k), res_sum, 4'd1);
      check_eq($sformatf("bp id %0d", k), res_id, 0);
    end
    res_rdy = 1'b1;
    #1;
    check_eq("bp release rdy", req_rdy, 4'b0010);
    tick();
    check_eq("bp new id", res_id, 1);
    check_eq("bp new sum", res_sum, 4'd5);
    req_vld = '0;
    tick();

    // Saturation on the CNT_W=2 instance
    s_req_a[3:0] = 4'd7;
    s_req_b[3:0] = 4'd7;
    s_req_vld = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("sat sum %0d", k), s_res_sum, 4'b1110);
      check_eq($sformatf("sat ovf %0d", k), s_res_ovf, 1);
      check_eq($sformatf("sat cnt %0d", k), s_ovf_cnt, (k < 3) ? k + 1 : 3);
    end
    s_req_vld = '0;

    // Reset in the middle of a stall
    res_rdy = 1'b0;
    set_ops(0, 4'd7, 4'd1);
    req_vld = 4'b0001;
    tick();
    check_eq("stall load vld", res_vld, 1);
    check_eq("stall load cnt", ovf_cnt, 1);
    req_vld = '0;
    tick();
    check_eq("stall hold vld", res_vld, 1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'd1);
    req_vld = 4'b1111;
    res_rdy = 1'b1;
    #1;
    check_eq("rst rdy zero", req_rdy, 4'b0000);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid rst vld", res_vld, 0);
    check_eq("mid rst cnt", ovf_cnt, 0);
    check_eq("mid rst sum", res_sum, 0);
    check_eq("mid rst rdy", req_rdy, 4'b0001);
    tick();
    check_eq("mid rst grant id", res_id, 0);
    check_eq("mid rst grant sum", res_sum, 4'd1);
    req_vld = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
